sdram_arbit: RTL and testbench

SDRAM access arbiter and refresh scheduler for the 100 MHz SDRAM controller. It holds the bus for the power-up init sequencer until init completes. It then grants the single SDRAM command/address bus to one of three users: auto-refresh (issued internally), the burst writer, and the burst reader. Fixed priority is refresh > write > read. It sits between the `sdram_init`/`sdram_write`/`sdram_read` blocks and the SDRAM pins.

---
 rtl/sdram_arbit.sv | 129 ++++++++++++
 tb/tb_sdram_arbit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter with an internal auto-refresh scheduler.
// Holds the bus for the init sequencer, then grants it with fixed priority
// refresh > write > read. Writers and readers yield cooperatively on ref_req.
module sdram_arbit #(
   parameter int unsigned REF_CYCLES = 780,
   parameter int unsigned TRFC       = 7
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [12:0] init_addr,
   output logic        ref_req,
   input  logic        wr_req,
   output logic        wr_en,
   input  logic        flag_wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [12:0] wr_addr,
   input  logic [1:0]  wr_bank,
   input  logic        rd_req,
   output logic        rd_en,
   input  logic        flag_rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [12:0] rd_addr,
   input  logic [1:0]  rd_bank,
   output logic [3:0]  sdram_cmd,
   output logic [12:0] sdram_addr,
   output logic [1:0]  sdram_bank
);

   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_REF   = 5'b00100,
      S_WR    = 5'b01000,
      S_RD    = 5'b10000
   } state_t;

   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [9:0] REF_LAST  = 10'(REF_CYCLES - 1);
   localparam logic [3:0] AREF_LAST = 4'(TRFC - 1);

   state_t      r_state;
   state_t      w_next;
   logic [9:0]  r_ref_cnt;
   logic [3:0]  r_aref_cnt;
   logic        r_ref_req;
   logic        w_ref_wrap;

   assign w_ref_wrap = (r_state != S_INIT) && (r_ref_cnt == REF_LAST);
   assign ref_req    = r_ref_req;

   // State register
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) r_state <= S_INIT;
      else          r_state <= w_next;
   end

   // Next-state logic: fixed priority refresh > write > read from S_ARBIT
   always_comb begin
      w_next = S_INIT;
      case (r_state)
         S_INIT:  w_next = init_end ? S_ARBIT : S_INIT;
         S_ARBIT: begin
            if (r_ref_req)   w_next = S_REF;
            else if (wr_req) w_next = S_WR;
            else if (rd_req) w_next = S_RD;
            else             w_next = S_ARBIT;
         end
         S_REF:   w_next = (r_aref_cnt == AREF_LAST) ? S_ARBIT : S_REF;
         S_WR:    w_next = flag_wr_end ? S_ARBIT : S_WR;
         S_RD:    w_next = flag_rd_end ? S_ARBIT : S_RD;
         default: w_next = S_INIT;
      endcase
   end

   // Refresh interval timer, held in S_INIT, wraps at REF_CYCLES-1
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)                          r_ref_cnt <= '0;
      else if (r_state == S_INIT || w_ref_wrap) r_ref_cnt <= '0;
      else                                   r_ref_cnt <= r_ref_cnt + 10'd1;
   end

   // Refresh request: set on timer wrap (a fresh wrap wins over the clear),
   // cleared on the first S_REF cycle; missed wraps collapse into one request
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)                                  r_ref_req <= 1'b0;
      else if (w_ref_wrap)                           r_ref_req <= 1'b1;
      else if (r_state == S_REF && r_aref_cnt == '0) r_ref_req <= 1'b0;
   end

   // Cycles spent in S_REF; zero whenever S_REF is not being continued
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)                               r_aref_cnt <= '0;
      else if (r_state == S_REF && w_next == S_REF) r_aref_cnt <= r_aref_cnt + 4'd1;
      else                                        r_aref_cnt <= '0;
   end

   // Output mux and grant decodes on current state
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_bank = '0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      case (r_state)
         S_INIT: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         S_REF:   sdram_cmd = (r_aref_cnt == '0) ? CMD_AREF : CMD_NOP;
         S_WR: begin
            sdram_cmd  = wr_cmd;
            sdram_addr = wr_addr;
            sdram_bank = wr_bank;
            wr_en      = 1'b1;
         end
         S_RD: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank;
            rd_en      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed phases plus randomized traffic, checked every cycle
// against a timestamp-based model of who owns the bus and when refresh is due.
module tb_sdram_arbit;

   localparam int REF_CYCLES = 780;
   localparam int TRFC       = 7;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

   logic        sclk = 1'b0;
   logic        s_rst_n = 1'b0;
   logic        init_end = 1'b0;
   logic [3:0]  init_cmd = CMD_NOP;
   logic [12:0] init_addr = '0;
   logic        ref_req;
   logic        wr_req = 1'b0;
   logic        wr_en;
   logic        flag_wr_end = 1'b0;
   logic [3:0]  wr_cmd = '0;
   logic [12:0] wr_addr = '0;
   logic [1:0]  wr_bank = '0;
   logic        rd_req = 1'b0;
   logic        rd_en;
   logic        flag_rd_end = 1'b0;
   logic [3:0]  rd_cmd = '0;
   logic [12:0] rd_addr = '0;
   logic [1:0]  rd_bank = '0;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_bank;

   sdram_arbit #(.REF_CYCLES(REF_CYCLES), .TRFC(TRFC)) dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_addr(init_addr), .ref_req(ref_req),
      .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
      .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
      .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
      .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
      .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
   );

   always #5 sclk = ~sclk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Model: bus owner plus timestamps (edge indices) of leaving init and entering refresh
   int cyc = 0;
   int t0 = 0;
   int ref_start = 0;
   int m_owner = O_INIT;
   bit m_pend = 1'b0;
   bit fix_init = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [21:0] dut_vec();
      return {ref_req, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank};
   endfunction

   function automatic logic [21:0] exp_vec();
      logic [3:0]  c;
      logic [12:0] a;
      logic [1:0]  b;
      logic        we, re;
      c = CMD_NOP; a = '0; b = '0; we = 1'b0; re = 1'b0;
      case (m_owner)
         O_INIT: begin c = init_cmd; a = init_addr; end
         O_REF:  c = (cyc == ref_start) ? CMD_AREF : CMD_NOP;
         O_WR:   begin c = wr_cmd; a = wr_addr; b = wr_bank; we = 1'b1; end
         O_RD:   begin c = rd_cmd; a = rd_addr; b = rd_bank; re = 1'b1; end
         default: ;
      endcase
      return {m_pend, we, re, c, a, b};
   endfunction

   task automatic model_edge();
      int  nxt;
      bit  wrap;
      cyc++;
      if (!s_rst_n) begin
         m_owner = O_INIT;
         m_pend  = 1'b0;
         return;
      end
      // Requests fall every REF_CYCLES edges counted from leaving init
      wrap = (m_owner != O_INIT) && (((cyc - t0) % REF_CYCLES) == 0);
      nxt = m_owner;
      case (m_owner)
         O_INIT: if (init_end) begin nxt = O_IDLE; t0 = cyc; end
         O_IDLE: begin
            if (m_pend)      begin nxt = O_REF; ref_start = cyc; end
            else if (wr_req) nxt = O_WR;
            else if (rd_req) nxt = O_RD;
         end
         O_REF:  if (cyc - ref_start == TRFC) nxt = O_IDLE;
         O_WR:   if (flag_wr_end) nxt = O_IDLE;
         O_RD:   if (flag_rd_end) nxt = O_IDLE;
         default: ;
      endcase
      if (m_owner == O_REF && cyc == ref_start + 1) m_pend = 1'b0;
      if (wrap) m_pend = 1'b1;
      m_owner = nxt;
   endtask

   task automatic rand_data();
      if (!fix_init) init_cmd = 4'($urandom);
      init_addr = 13'($urandom);
      wr_cmd = 4'($urandom); wr_addr = 13'($urandom); wr_bank = 2'($urandom);
      rd_cmd = 4'($urandom); rd_addr = 13'($urandom); rd_bank = 2'($urandom);
   endtask

   task automatic step();
      rand_data();
      @(posedge sclk);
      model_edge();
      #1;
      check("bus", dut_vec(), exp_vec());
   endtask

   initial begin
      int rise_delta;
      int arefs;
      int k;
      bit prev_ref;

      // Reset and init hold
      #1;
      check("reset_bus", dut_vec(), exp_vec());
      check("reset_ref_req", ref_req, 1'b0);
      #10;
      s_rst_n = 1'b1;
      for (int i = 0; i < 99; i++) step();
      check("init_grants", {ref_req, wr_en, rd_en}, 3'b000);
      init_end = 1'b1;
      step();
      check("left_init_nop", sdram_cmd, CMD_NOP);

      // Idle refresh cadence
      rise_delta = -1; arefs = 0; prev_ref = 1'b0;
      while (cyc < t0 + 1700) begin
         step();
         if (ref_req && !prev_ref && rise_delta < 0) rise_delta = cyc - t0;
         if (sdram_cmd == CMD_AREF) arefs++;
         prev_ref = ref_req;
      end
      check("first_ref_rise", rise_delta, REF_CYCLES);
      check("idle_aref_count", arefs, 2);

      // Simultaneous write/read requests: write first, read after one arbit cycle
      wr_req = 1'b1; rd_req = 1'b1;
      step();
      check("wr_first", {wr_en, rd_en}, 2'b10);
      for (int i = 0; i < 3; i++) step();
      wr_req = 1'b0; flag_wr_end = 1'b1;
      step();
      flag_wr_end = 1'b0;
      check("gap_cycle", {wr_en, rd_en}, 2'b00);
      step();
      check("rd_after_wr", rd_en, 1'b1);
      check("rd_cmd_muxed", sdram_cmd, rd_cmd);

      // Refresh request during a read; reader yields 5 cycles later
      k = 0;
      while (!ref_req && k < 1000) begin step(); k++; end
      if (k == 1000) check("wait_ref_in_rd", 0, 1);
      check("ref_seen_in_rd", rd_en, 1'b1);
      for (int i = 0; i < 5; i++) step();
      flag_rd_end = 1'b1;
      step();
      flag_rd_end = 1'b0;
      check("rd_yield", rd_en, 1'b0);
      step();
      check("aref_after_yield", sdram_cmd, CMD_AREF);
      k = 0;
      while (!rd_en && k < 20) begin step(); k++; end
      check("rd_regrant_lat", k, 8);
      flag_rd_end = 1'b1; rd_req = 1'b0;
      step();
      flag_rd_end = 1'b0;

      // Long write hold with spurious read-end pulses
      wr_req = 1'b1;
      k = 0;
      while (!wr_en && k < 30) begin step(); k++; end
      if (k == 30) check("wait_wr_grant", 0, 1);
      for (int i = 0; i < 1600; i++) begin
         flag_rd_end = ($urandom_range(0, 6) == 0);
         step();
      end
      flag_rd_end = 1'b0;
      check("ref_held", ref_req, 1'b1);
      check("wr_kept", wr_en, 1'b1);
      wr_req = 1'b0; flag_wr_end = 1'b1;
      step();
      flag_wr_end = 1'b0;
      arefs = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (sdram_cmd == CMD_AREF) arefs++;
      end
      check("single_aref", arefs, 1);

      // Randomized traffic, spurious flags, init_end wiggle, occasional reset
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) wr_req = ~wr_req;
         if ($urandom_range(0, 7) == 0) rd_req = ~rd_req;
         flag_wr_end = ($urandom_range(0, 9) == 0);
         flag_rd_end = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) init_end = ~init_end;
         if (!s_rst_n) begin
            s_rst_n = 1'b1;
            init_end = 1'b1;
         end else if ($urandom_range(0, 1499) == 0) begin
            s_rst_n = 1'b0;
            m_owner = O_INIT;
            m_pend = 1'b0;
            #1;
            check("rand_async_rst", dut_vec(), exp_vec());
         end
         step();
      end
      if (!s_rst_n) s_rst_n = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      init_end = 1'b1;

      // Reset in the middle of a refresh
      k = 0;
      while (!(m_owner == O_REF && cyc - ref_start == 3) && k < 2000) begin step(); k++; end
      if (k == 2000) check("wait_mid_ref", 0, 1);
      fix_init = 1'b1;
      init_cmd = CMD_NOP;
      s_rst_n = 1'b0;
      m_owner = O_INIT;
      m_pend = 1'b0;
      #1;
      check("rst_ref_req", ref_req, 1'b0);
      check("rst_cmd_init", sdram_cmd, init_cmd);
      check("rst_addr_init", sdram_addr, init_addr);
      check("rst_bus", dut_vec(), exp_vec());
      init_end = 1'b0;
      step();
      step();
      s_rst_n = 1'b1;
      arefs = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (sdram_cmd == CMD_AREF) arefs++;
      end
      check("no_aref_in_init", arefs, 0);
      init_end = 1'b1;
      arefs = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         if (sdram_cmd == CMD_AREF) arefs++;
      end
      check("aref_after_reinit", arefs, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
